// File: rtl/fetch_stage.sv
// Instruction fetch: PC, prefetch queue over a 1-cycle synchronous imem, and
// one-word-per-toggle delivery to the issuer with branch redirect/flush.
// state   | meaning
// IDLE    | no request since reset
// WAIT    | request pending, queue and response empty
// PRESENT | word held on dataOut (readyOut rises after one setup cycle)
module fetch_stage #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          QDEPTH       = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        triggerIn,
    output logic        readyOut,
    output logic [31:0] dataOut,
    output logic        imem_en,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
);
    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;
    localparam logic [31:0] RESET_PC = RESET_VECTOR & ~32'h3;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_PRESENT} state_e;

    state_e        state_q, state_d;
    logic          trig_meta_q, trig_s_q, trig_prev_q;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   queue_q [QDEPTH];
    logic [31:0]   queue_d [QDEPTH];
    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          inflight_q, kill_q;
    logic          ready_q, ready_d;
    logic [31:0]   data_q, data_d;

    logic          req, resp_valid, avail, want, pop, pop_entry, push, issue;
    logic [31:0]   head_word;

    always_comb begin
        req        = trig_s_q != trig_prev_q;
        resp_valid = inflight_q && !kill_q;
        // A redirect flushes everything, so nothing may be popped in that cycle.
        avail      = !redirect && ((count_q != '0) || resp_valid);
        head_word  = (count_q != '0) ? queue_q[head_q] : imem_rdata;
        want       = req || (state_q == S_WAIT);
        pop        = want && avail;
        pop_entry  = pop && (count_q != '0);
        push       = resp_valid && !redirect && !(pop && (count_q == '0));
        issue      = !redirect &&
                     (({1'b0, count_q} + {{CW{1'b0}}, inflight_q}) < (CW+1)'(QDEPTH));
        imem_en    = issue && !reset;
        imem_addr  = pc_q;
        readyOut   = ready_q;
        dataOut    = data_q;
    end

    always_comb begin
        state_d = state_q;
        ready_d = ready_q;
        data_d  = data_q;
        if (want) begin
            ready_d = 1'b0;
            if (pop) begin
                data_d  = head_word;
                state_d = S_PRESENT;
            end else begin
                state_d = S_WAIT;
            end
        end else if (state_q == S_PRESENT) begin
            ready_d = 1'b1;
        end
    end

    always_comb begin
        queue_d = queue_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        pc_d    = pc_q;
        if (redirect) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            pc_d    = redirect_pc & ~32'h3;
        end else begin
            if (push) begin
                queue_d[tail_q] = imem_rdata;
                tail_d          = tail_q + PW'(1);
            end
            if (pop_entry) head_d = head_q + PW'(1);
            count_d = count_q + CW'(push) - CW'(pop_entry);
            if (issue) pc_d = pc_q + 32'd4;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            trig_meta_q <= triggerIn;
            trig_s_q    <= triggerIn;
            trig_prev_q <= triggerIn;
            state_q     <= S_IDLE;
            pc_q        <= RESET_PC;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            inflight_q  <= 1'b0;
            kill_q      <= 1'b0;
            ready_q     <= 1'b0;
            data_q      <= '0;
        end else begin
            trig_meta_q <= triggerIn;
            trig_s_q    <= trig_meta_q;
            trig_prev_q <= trig_s_q;
            state_q     <= state_d;
            pc_q        <= pc_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            inflight_q  <= issue;
            kill_q      <= redirect;
            ready_q     <= ready_d;
            data_q      <= data_d;
        end
    end

    always_ff @(posedge clk) begin
        queue_q <= queue_d;
    end
endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed steps plus randomized request/redirect
// sequences checked against a program-order word model.
module tb_fetch_stage;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        triggerIn = 1'b0;
    logic        readyOut;
    logic [31:0] dataOut;
    logic        imem_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = '0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;

    logic        trig_w = 1'b0;
    logic        ready_w;
    logic [31:0] data_w;
    logic        en_w;
    logic [31:0] addr_w;
    logic [31:0] rdata_w = '0;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_addr = '0;
    logic [31:0] last_word = '0;
    logic [31:0] wrap_log [$];

    fetch_stage #(.RESET_VECTOR(32'h0000_0000), .QDEPTH(2)) dut (
        .clk(clk), .reset(reset), .triggerIn(triggerIn), .readyOut(readyOut),
        .dataOut(dataOut), .imem_en(imem_en), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .redirect(redirect), .redirect_pc(redirect_pc)
    );

    fetch_stage #(.RESET_VECTOR(32'hFFFF_FFF8), .QDEPTH(2)) dut_wrap (
        .clk(clk), .reset(reset), .triggerIn(trig_w), .readyOut(ready_w),
        .dataOut(data_w), .imem_en(en_w), .imem_addr(addr_w),
        .imem_rdata(rdata_w), .redirect(1'b0), .redirect_pc(32'h0)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hE000_0000 + (a >> 2);
    endfunction

    always @(posedge clk) begin
        if (imem_en) imem_rdata <= mem_word(imem_addr);
        if (en_w)    rdata_w    <= mem_word(addr_w);
    end

    always @(negedge clk) begin
        #1;
        if (en_w) wrap_log.push_back(addr_w);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One toggle; optional redirect rd_delay negedges after the toggle (-1: none).
    task automatic do_request(input string tag, input int rd_delay, input logic [31:0] rd_target);
        logic [31:0] prev_data;
        logic [31:0] exp;
        bit          seen_low;
        bit          got;
        if (rd_delay == 0) begin
            redirect    = 1'b1;
            redirect_pc = rd_target;
            exp_addr    = rd_target & ~32'h3;
        end
        triggerIn = ~triggerIn;
        seen_low  = 1'b0;
        got       = 1'b0;
        prev_data = dataOut;
        for (int n = 1; n <= 40 && !got; n++) begin
            @(negedge clk);
            redirect = (n == rd_delay);
            if (n == rd_delay) begin
                redirect_pc = rd_target;
                exp_addr    = rd_target & ~32'h3;
            end
            if (!readyOut) seen_low = 1'b1;
            if (seen_low && readyOut) got = 1'b1;
            else prev_data = dataOut;
        end
        redirect  = 1'b0;
        exp       = mem_word(exp_addr);
        exp_addr  = exp_addr + 32'd4;
        last_word = exp;
        check({tag, "_ready"}, 32'(got), 32'd1);
        check({tag, "_data"}, dataOut, exp);
        check({tag, "_setup"}, prev_data, exp);
    endtask

    task automatic hold_gap(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            check("gap_ready", 32'(readyOut), 32'd1);
            check("gap_data", dataOut, last_word);
        end
    endtask

    initial begin
        int          en_count;
        int          hi_count;
        logic [31:0] second_addr;
        logic [31:0] tgt;

        // Reset state and initial prefetch
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(readyOut), 32'd0);
        check("rst_data", dataOut, 32'd0);
        check("rst_en", 32'(imem_en), 32'd0);
        check("rst_addr", imem_addr, 32'd0);
        reset = 1'b0;
        #1;
        check("first_en", 32'(imem_en), 32'd1);
        check("first_addr", imem_addr, 32'd0);
        en_count    = 1;
        second_addr = 32'hDEAD_BEEF;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (imem_en) begin
                en_count++;
                if (en_count == 2) second_addr = imem_addr;
            end
        end
        check("fill_en_count", 32'(en_count), 32'd2);
        check("fill_second_addr", second_addr, 32'd4);
        check("fill_en_stopped", 32'(imem_en), 32'd0);
        check("fill_ready_low", 32'(readyOut), 32'd0);

        // First rise and fall, wrap instance popped alongside
        exp_addr = 32'd0;
        trig_w   = 1'b1;
        do_request("word_rise", -1, 32'd0);
        check("wrap_ready", 32'(ready_w), 32'd1);
        check("wrap_data", data_w, 32'h1FFF_FFFE);
        do_request("word_fall", -1, 32'd0);
        check("wrap_log_len", 32'(wrap_log.size() >= 3), 32'd1);
        check("wrap_addr0", (wrap_log.size() > 0) ? wrap_log[0] : 32'hDEAD_BEEF, 32'hFFFF_FFF8);
        check("wrap_addr1", (wrap_log.size() > 1) ? wrap_log[1] : 32'hDEAD_BEEF, 32'hFFFF_FFFC);
        check("wrap_addr2", (wrap_log.size() > 2) ? wrap_log[2] : 32'hDEAD_BEEF, 32'h0000_0000);

        // Six more toggles with varying gaps -> words 2..7
        for (int i = 0; i < 6; i++) begin
            hold_gap($urandom_range(0, 4));
            do_request("seq_word", -1, 32'd0);
        end
        check("seq_last", last_word, 32'hE000_0007);

        // Redirect with one word queued and one in flight
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        check("rd_en0", 32'(imem_en), 32'd1);
        @(negedge clk);
        check("rd_en1", 32'(imem_en), 32'd1);
        check("rd_addr1", imem_addr, 32'd4);
        @(negedge clk);
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0103;
        #1;
        check("rd_no_issue", 32'(imem_en), 32'd0);
        @(negedge clk);
        redirect = 1'b0;
        #1;
        check("rd_target_en", 32'(imem_en), 32'd1);
        check("rd_target_addr", imem_addr, 32'h0000_0100);
        exp_addr = 32'h0000_0100;
        do_request("rd_word0", -1, 32'd0);
        check("rd_word0_abs", last_word, 32'hE000_0040);
        do_request("rd_word1", -1, 32'd0);

        // Randomized requests with redirects in PRESENT and around the request
        for (int i = 0; i < 24; i++) begin
            int mode;
            hold_gap($urandom_range(0, 3));
            mode = $urandom_range(0, 5);
            tgt  = $urandom;
            if (mode == 0) begin
                redirect    = 1'b1;
                redirect_pc = tgt;
                exp_addr    = tgt & ~32'h3;
                @(negedge clk);
                redirect = 1'b0;
                check("rnd_rd_ready_kept", 32'(readyOut), 32'd1);
                check("rnd_rd_data_kept", dataOut, last_word);
                do_request("rnd_after_rd", -1, 32'd0);
            end else if (mode <= 3) begin
                do_request("rnd_rd_req", mode - 1, tgt);
            end else begin
                do_request("rnd_word", -1, 32'd0);
            end
        end

        // Reset while PRESENT with triggerIn high
        if (triggerIn == 1'b0) do_request("pre_reset", -1, 32'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("mid_rst_ready", 32'(readyOut), 32'd0);
        reset = 1'b0;
        #1;
        check("mid_rst_pc", imem_addr, 32'd0);
        hi_count = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (readyOut) hi_count++;
        end
        check("mid_rst_no_word", 32'(hi_count), 32'd0);
        exp_addr = 32'd0;
        do_request("mid_rst_fresh", -1, 32'd0);
        check("mid_rst_fresh_abs", last_word, 32'hE000_0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
